// File: rtl/pulse_scheduler.sv
// Time-shared pulse-width meter: one width counter and one watchdog are rotated
// round-robin over the enabled input channels, one result presented at a time.
module pulse_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 11,
    parameter int TMO = 2000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in,
    input  logic           en,
    input  logic [NCH-1:0] chan_en,
    input  logic           ack,
    output logic           ready,
    output logic [W-1:0]   data,
    output logic [2:0]     ch,
    output logic           tmo,
    output logic           ovf,
    output logic           busy
);

    typedef enum logic [2:0] {IDLE, SETTLE, ARM, WAIT_HIGH, COUNT, DONE} state_t;

    localparam logic [W-1:0] TMO_W   = W'(TMO);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    state_t       state_reg, state_next;
    logic [2:0]   sel_reg, sel_next;
    logic         in_q_reg;
    logic [W-1:0] cnt_reg, cnt_next;
    logic [W-1:0] wd_reg, wd_next;
    logic [W-1:0] wd_inc;
    logic         ovf_flag_reg, ovf_flag_next;
    logic         ready_reg, ready_next;
    logic [W-1:0] data_reg, data_next;
    logic [2:0]   ch_reg, ch_next;
    logic         tmo_reg, tmo_next;
    logic         ovf_reg, ovf_next;

    // Padded to 8 so a 3-bit channel index is always in range.
    logic [7:0]   in_pad;
    logic [7:0]   chan_en_pad;
    assign in_pad      = 8'(in);
    assign chan_en_pad = 8'(chan_en);

    // cand[gi] is the channel gi+1 positions after the last one selected.
    logic [2:0]     cand [NCH];
    logic [NCH-1:0] hit;
    logic [2:0]     pick;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            localparam int OFF = gi + 1;
            logic [3:0] sum;
            assign sum       = {1'b0, sel_reg} + 4'(OFF);
            assign cand[gi]  = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
            assign hit[gi]   = chan_en_pad[cand[gi]];
        end
    endgenerate

    always_comb begin
        pick = cand[0];
        for (int k = NCH - 1; k >= 0; k--) begin
            if (hit[k]) pick = cand[k];
        end
    end

    assign wd_inc = wd_reg + W'(1);

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        cnt_next      = cnt_reg;
        wd_next       = wd_reg;
        ovf_flag_next = ovf_flag_reg;
        ready_next    = ready_reg;
        data_next     = data_reg;
        ch_next       = ch_reg;
        tmo_next      = tmo_reg;
        ovf_next      = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (en && (|chan_en)) begin
                    sel_next   = pick;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                cnt_next      = '0;
                wd_next       = '0;
                ovf_flag_next = 1'b0;
                state_next    = ARM;
            end
            ARM, WAIT_HIGH: begin
                wd_next = wd_inc;
                // Watchdog expiry wins over any edge seen in the same cycle.
                if (wd_inc == TMO_W) begin
                    data_next  = '0;
                    tmo_next   = 1'b1;
                    ovf_next   = 1'b0;
                    ch_next    = sel_reg;
                    ready_next = 1'b1;
                    state_next = DONE;
                end else if (state_reg == ARM) begin
                    if (!in_q_reg) state_next = WAIT_HIGH;
                end else if (in_q_reg) begin
                    cnt_next   = W'(1);
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (in_q_reg) begin
                    if (cnt_reg == CNT_MAX) ovf_flag_next = 1'b1;
                    else                    cnt_next      = cnt_reg + W'(1);
                end else begin
                    data_next  = cnt_reg;
                    ovf_next   = ovf_flag_reg;
                    tmo_next   = 1'b0;
                    ch_next    = sel_reg;
                    ready_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    ready_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            sel_reg      <= 3'(NCH - 1);
            in_q_reg     <= 1'b0;
            cnt_reg      <= '0;
            wd_reg       <= '0;
            ovf_flag_reg <= 1'b0;
            ready_reg    <= 1'b0;
            data_reg     <= '0;
            ch_reg       <= '0;
            tmo_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            in_q_reg     <= in_pad[sel_reg];
            cnt_reg      <= cnt_next;
            wd_reg       <= wd_next;
            ovf_flag_reg <= ovf_flag_next;
            ready_reg    <= ready_next;
            data_reg     <= data_next;
            ch_reg       <= ch_next;
            tmo_reg      <= tmo_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign ready = ready_reg;
    assign data  = data_reg;
    assign ch    = ch_reg;
    assign tmo   = tmo_reg;
    assign ovf   = ovf_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: stimulus queues expected results,
// monitors pop and compare whenever a DUT raises ready.
module tb_pulse_scheduler;
    localparam int NCH = 4;
    localparam int W   = 11;
    localparam int TMO = 2000;
    localparam int TMO4 = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NCH-1:0] in, chan_en, in4, chan_en4;
    logic           en, ack, en4, ack4;
    logic           ready, tmo, ovf, busy;
    logic [W-1:0]   data;
    logic [2:0]     ch;
    logic           ready4, tmo4, ovf4, busy4;
    logic [3:0]     data4;
    logic [2:0]     ch4;

    pulse_scheduler #(.NCH(NCH), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .in(in), .en(en), .chan_en(chan_en), .ack(ack),
        .ready(ready), .data(data), .ch(ch), .tmo(tmo), .ovf(ovf), .busy(busy)
    );

    pulse_scheduler #(.NCH(NCH), .W(4), .TMO(TMO4)) dut4 (
        .clk(clk), .rst(rst), .in(in4), .en(en4), .chan_en(chan_en4), .ack(ack4),
        .ready(ready4), .data(data4), .ch(ch4), .tmo(tmo4), .ovf(ovf4), .busy(busy4)
    );

    typedef struct packed {
        logic [10:0] data;
        logic [2:0]  ch;
        logic        tmo;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t mk(input int d, input int c, input logic t, input logic o);
        exp_t e;
        e.data = 11'(d);
        e.ch   = 3'(c);
        e.tmo  = t;
        e.ovf  = o;
        return e;
    endfunction

    // Monitor for the default-width instance.
    logic ready_prev = 1'b0;
    logic have_cur = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            $display("txn dut ch=%0d data=%0d tmo=%0d ovf=%0d", ch, data, tmo, ovf);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                have_cur = 1'b0;
                $display("FAIL unexpected_result: got ch=%0d data=%0d, expected no result", ch, data);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                check("data", 32'(data), 32'(cur.data));
                check("ch",   32'(ch),   32'(cur.ch));
                check("tmo",  32'(tmo),  32'(cur.tmo));
                check("ovf",  32'(ovf),  32'(cur.ovf));
            end
        end else if (ready && have_cur) begin
            check("held_result", {16'd0, data, ch, tmo, ovf}, {16'd0, cur.data, cur.ch, cur.tmo, cur.ovf});
        end
        ready_prev = ready;
    end

    // Monitor for the 4-bit instance.
    logic ready4_prev = 1'b0;
    exp_t cur4;
    always @(negedge clk) begin
        if (ready4 && !ready4_prev) begin
            $display("txn dut4 ch=%0d data=%0d tmo=%0d ovf=%0d", ch4, data4, tmo4, ovf4);
            if (exp4_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result4: got ch=%0d data=%0d, expected no result", ch4, data4);
            end else begin
                cur4 = exp4_q.pop_front();
                check("data4", 32'(data4), 32'(cur4.data));
                check("ch4",   32'(ch4),   32'(cur4.ch));
                check("tmo4",  32'(tmo4),  32'(cur4.tmo));
                check("ovf4",  32'(ovf4),  32'(cur4.ovf));
            end
        end
        ready4_prev = ready4;
    end

    task automatic wait_ready(input int limit);
        int k = 0;
        while (!ready && k < limit) begin
            tick();
            k++;
        end
        check("ready_within_bound", 32'(ready), 32'd1);
    endtask

    task automatic wait_ready4(input int limit);
        int k = 0;
        while (!ready4 && k < limit) begin
            tick();
            k++;
        end
        check("ready4_within_bound", 32'(ready4), 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ready_after_ack", 32'(ready), 32'd0);
    endtask

    task automatic do_ack4();
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        check("ready4_after_ack", 32'(ready4), 32'd0);
    endtask

    task automatic pulse(input int c, input int n);
        in[c] = 1'b1;
        tick(n);
        in[c] = 1'b0;
    endtask

    // One expected measurement on the main instance: arm, pulse, collect, ack.
    task automatic measure(input int c, input int n);
        tick(6);
        exp_q.push_back(mk(n, c, 1'b0, 1'b0));
        pulse(c, n);
        wait_ready(50);
        do_ack();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in = '0; en = 1'b0; chan_en = '0; ack = 1'b0;
        in4 = '0; en4 = 1'b0; chan_en4 = '0; ack4 = 1'b0;
        tick(2);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_ch",    32'(ch),    32'd0);
        check("rst_tmo",   32'(tmo),   32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ready4", 32'(ready4), 32'd0);
        rst = 1'b1;

        // Single channel, 5-cycle pulse, held until ack.
        chan_en = 4'b0001;
        en = 1'b1;
        tick(6);
        check("busy_armed", 32'(busy), 32'd1);
        exp_q.push_back(mk(5, 0, 1'b0, 1'b0));
        pulse(0, 5);
        wait_ready(50);
        tick(3);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_data",  32'(data),  32'd5);
        do_ack();

        // Dropping en and the channel mask mid-measurement does not abort it.
        tick(6);
        en = 1'b0;
        chan_en = 4'b0000;
        exp_q.push_back(mk(6, 0, 1'b0, 1'b0));
        pulse(0, 6);
        wait_ready(50);
        do_ack();
        tick(3);
        check("idle_after_en_low", 32'(busy), 32'd0);

        // Round-robin over ch0/1/3 from a fresh reset, with noise on ch2.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        chan_en = 4'b1011;
        en = 1'b1;
        in[2] = 1'b1;
        measure(0, 3);
        in[2] = 1'b0;
        measure(1, 7);
        in[2] = 1'b1;
        measure(3, 9);
        in[2] = 1'b0;
        measure(0, 2);

        // Channel 1 already high when armed: partial pulse discarded.
        in[1] = 1'b1;
        tick(8);
        check("armed_on_high", 32'(busy), 32'd1);
        in[1] = 1'b0;
        tick(2);
        exp_q.push_back(mk(4, 1, 1'b0, 1'b0));
        pulse(1, 4);
        wait_ready(50);
        do_ack();

        // Channel 3 stays low: watchdog result, then rotation continues to ch0.
        exp_q.push_back(mk(0, 3, 1'b1, 1'b0));
        wait_ready(TMO + 50);
        do_ack();
        measure(0, 3);

        // Reset together with ack while a result is held.
        tick(6);
        exp_q.push_back(mk(5, 1, 1'b0, 1'b0));
        pulse(1, 5);
        wait_ready(50);
        rst = 1'b0;
        ack = 1'b1;
        tick();
        rst = 1'b1;
        ack = 1'b0;
        check("rst_ack_ready", 32'(ready), 32'd0);
        check("rst_ack_data",  32'(data),  32'd0);
        check("rst_ack_busy",  32'(busy),  32'd0);
        measure(0, 4);
        en = 1'b0;

        // 4-bit instance: boundary below saturation, saturation, and timeout.
        chan_en4 = 4'b0001;
        en4 = 1'b1;
        tick(5);
        exp4_q.push_back(mk(15, 0, 1'b0, 1'b0));
        in4[0] = 1'b1;
        tick(15);
        in4[0] = 1'b0;
        wait_ready4(20);
        do_ack4();
        tick(5);
        exp4_q.push_back(mk(15, 0, 1'b0, 1'b1));
        in4[0] = 1'b1;
        tick(20);
        in4[0] = 1'b0;
        wait_ready4(20);
        do_ack4();
        exp4_q.push_back(mk(0, 0, 1'b1, 1'b0));
        wait_ready4(40);
        en4 = 1'b0;
        do_ack4();

        tick(5);
        check("queue_drained",  32'(exp_q.size()),  32'd0);
        check("queue4_drained", 32'(exp4_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
